// File: rtl/const_weight_gen_pkg.sv
// Shared widths, FSM state type and pattern-mask helpers for the constant-weight enumerator.
// Pure declarations: no logic, no latency, no flow control.
package cwg_pkg;

    localparam int WIDTH = 12;
    localparam int CNT_W = 5;
    localparam int IDX_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Lowest word of weight k: ones packed at the LSB end.
    function automatic logic [WIDTH-1:0] first_word(input logic [CNT_W-1:0] k);
        logic [WIDTH:0] ones;
        ones = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
        return ones[WIDTH-1:0];
    endfunction

    // Highest word of weight k: ones packed at the MSB end. Assumes k <= WIDTH.
    function automatic logic [WIDTH-1:0] last_mask(input logic [CNT_W-1:0] k);
        logic [WIDTH:0] ones;
        logic [WIDTH:0] shifted;
        ones    = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
        shifted = ones << (CNT_W'(WIDTH) - k);
        return shifted[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/const_weight_gen_if.sv
// Control and valid/ready output stream of the enumerator; master = requester/consumer side.
// Wires only: no latency; out_ready is the sole backpressure input.
interface const_weight_gen_if;
    import cwg_pkg::*;

    logic             start;
    logic [CNT_W-1:0] k;
    logic             busy;
    logic             err;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             done;

    modport master (
        output start, k, out_ready,
        input  busy, err, out_valid, out_word, out_index, out_last, done
    );

    modport slave (
        input  start, k, out_ready,
        output busy, err, out_valid, out_word, out_index, out_last, done
    );

endinterface

// File: rtl/const_weight_gen_tz_count.sv
// Trailing-zero count of a word; an all-zero word reports W.
// Purely combinational, no flow control.
module tz_count #(
    parameter int W  = 12,
    parameter int CW = 5
) (
    input  logic [W-1:0]  word,
    output logic [CW-1:0] tz
);

    // Scan MSB to LSB so the lowest set bit wins.
    always_comb begin
        tz = CW'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (word[i]) tz = CW'(i);
        end
    end

endmodule

// File: rtl/const_weight_gen.sv
// Enumerates every WIDTH-bit word of weight k in ascending order; first word one cycle after start, then one per cycle.
// Word/index/last hold while out_valid && !out_ready; out_valid is state-registered and never depends on out_ready.
module const_weight_gen
    import cwg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    const_weight_gen_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] tz;
    logic [WIDTH:0]   x, c, r, nxt;

    tz_count #(.W(WIDTH), .CW(CNT_W)) u_tz (
        .word (word_q),
        .tz   (tz)
    );

    // Gosper step with the division by the lowest set bit done as a shift by tz.
    always_comb begin
        x   = {1'b0, word_q};
        c   = x & (-x);
        r   = x + c;
        nxt = (((r ^ x) >> 2) >> tz) | r;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        index_d = index_q;
        k_d     = k_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k > CNT_W'(WIDTH)) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = bus.k;
                        word_d  = first_word(bus.k);
                        index_d = '0;
                        last_d  = (first_word(bus.k) == last_mask(bus.k));
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = FIN;
                    end else begin
                        word_d  = nxt[WIDTH-1:0];
                        index_d = index_q + 1'b1;
                        last_d  = (nxt[WIDTH-1:0] == last_mask(k_q));
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            index_q <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            index_q <= index_d;
            k_q     <= k_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = err_q;
    assign bus.out_word  = word_q;
    assign bus.out_index = index_q;
    assign bus.out_last  = last_q;

endmodule
